// File: rtl/systolic_array_4x4.sv
// systolic_array_4x4: 4x4 output-stationary signed MAC array, drained in snake order via the SE corner
// Optional feature: define SYSTOLIC_SKEW_EN to skew edge inputs internally (row r / column c delayed r / c cycles).
// Ports: clk, rst (sync, active-high)
//   west_in/west_vld   A operand + valid per row, enters PE(r,0)
//   north_in/north_vld B operand + valid per column, enters PE(0,c)
//   acc_clr            clear accumulators and in-flight valids, aborts a drain
//   out_phase          drain request, level, freezes the compute pipeline while high
//   se_valid/se_c      one drained accumulator per beat
module systolic_array_4x4 #(
   parameter int DW   = 16,
   parameter int ACCW = 40
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [3:0][DW-1:0] west_in,
   input  logic [3:0]         west_vld,
   input  logic [3:0][DW-1:0] north_in,
   input  logic [3:0]         north_vld,
   input  logic               acc_clr,
   input  logic               out_phase,
   output logic               se_valid,
   output logic [ACCW-1:0]    se_c
);
   typedef enum logic [1:0] {D_IDLE, D_RUN, D_DONE} d_state_t;
   logic [DW-1:0]   ea [4];
   logic [DW-1:0]   eb [4];
   logic            eav [4];
   logic            ebv [4];
   logic [DW-1:0]   a [4][4];
   logic [DW-1:0]   b [4][4];
   logic            av [4][4];
   logic            bv [4][4];
   logic [ACCW-1:0] acc [4][4];
   logic [ACCW-1:0] snake [16];
   logic [ACCW-1:0] snap [16];
   d_state_t        st, st_n;
   logic [3:0]      cnt;
   logic            load, beat;

   for (genvar i = 0; i < 4; i++) begin : g_edge
`ifdef SYSTOLIC_SKEW_EN
      if (i == 0) begin : g_direct
         assign ea[i]  = west_in[i];
         assign eav[i] = west_vld[i];
         assign eb[i]  = north_in[i];
         assign ebv[i] = north_vld[i];
      end else begin : g_delay
         logic [DW-1:0] wd [i];
         logic [DW-1:0] nd [i];
         logic          wv [i];
         logic          nv [i];
         always_ff @(posedge clk)
            if (rst) begin
               for (int j = 0; j < i; j++) begin
                  wd[j] <= '0;
                  nd[j] <= '0;
                  wv[j] <= 1'b0;
                  nv[j] <= 1'b0;
               end
            end else if (acc_clr) begin
               for (int j = 0; j < i; j++) begin
                  wv[j] <= 1'b0;
                  nv[j] <= 1'b0;
               end
            end else if (!out_phase) begin
               wd[0] <= west_in[i];
               wv[0] <= west_vld[i];
               nd[0] <= north_in[i];
               nv[0] <= north_vld[i];
               for (int j = 1; j < i; j++) begin
                  wd[j] <= wd[j-1];
                  wv[j] <= wv[j-1];
                  nd[j] <= nd[j-1];
                  nv[j] <= nv[j-1];
               end
            end
         assign ea[i]  = wd[i-1];
         assign eav[i] = wv[i-1];
         assign eb[i]  = nd[i-1];
         assign ebv[i] = nv[i-1];
      end
`else
      assign ea[i]  = west_in[i];
      assign eav[i] = west_vld[i];
      assign eb[i]  = north_in[i];
      assign ebv[i] = north_vld[i];
`endif
   end

   for (genvar r = 0; r < 4; r++) begin : g_row
      for (genvar c = 0; c < 4; c++) begin : g_col
         logic [DW-1:0]          ai, bi, ar, br;
         logic                   aiv, biv, arv, brv;
         logic [ACCW-1:0]        accr;
         logic signed [2*DW-1:0] p;
         // inputs arrive from the west / north neighbour, or from the edge on row/col 0
         assign ai  = (c == 0) ? ea[r]  : a[r][(c == 0) ? 0 : c - 1];
         assign aiv = (c == 0) ? eav[r] : av[r][(c == 0) ? 0 : c - 1];
         assign bi  = (r == 0) ? eb[c]  : b[(r == 0) ? 0 : r - 1][c];
         assign biv = (r == 0) ? ebv[c] : bv[(r == 0) ? 0 : r - 1][c];
         assign p   = $signed(ai) * $signed(bi);
         always_ff @(posedge clk)
            if (rst) begin
               ar   <= '0;
               br   <= '0;
               arv  <= 1'b0;
               brv  <= 1'b0;
               accr <= '0;
            end else if (acc_clr) begin
               arv  <= 1'b0;
               brv  <= 1'b0;
               accr <= '0;
            end else if (!out_phase) begin
               ar  <= ai;
               br  <= bi;
               arv <= aiv;
               brv <= biv;
               if (aiv && biv) accr <= accr + {{(ACCW-2*DW){p[2*DW-1]}}, p};
            end
         assign a[r][c]   = ar;
         assign b[r][c]   = br;
         assign av[r][c]  = arv;
         assign bv[r][c]  = brv;
         assign acc[r][c] = accr;
      end
   end

   // snake order: bottom row right-to-left, next row left-to-right, alternating upward
   for (genvar i = 0; i < 16; i++) begin : g_snake
      localparam int SR = 3 - i / 4;
      localparam int SC = (SR % 2 == 1) ? 3 - i % 4 : i % 4;
      assign snake[i] = acc[SR][SC];
   end

   always_ff @(posedge clk)
      st <= (rst || acc_clr) ? D_IDLE : st_n;

   always_comb
      st_n = (st == D_IDLE) ? (out_phase ? D_RUN : D_IDLE)
           : (st == D_RUN)  ? ((out_phase && cnt == 4'd15) ? D_DONE : D_RUN)
           : (out_phase ? D_DONE : D_IDLE);

   always_comb begin
      load = (st == D_IDLE) && out_phase;
      beat = (st == D_RUN) && out_phase;
   end

   always_ff @(posedge clk)
      if (rst) begin
         cnt      <= '0;
         se_valid <= 1'b0;
         se_c     <= '0;
         for (int i = 0; i < 16; i++) snap[i] <= '0;
      end else if (acc_clr) begin
         cnt      <= '0;
         se_valid <= 1'b0;
      end else begin
         se_valid <= beat;
         if (load) begin
            cnt <= '0;
            for (int i = 0; i < 16; i++) snap[i] <= snake[i];
         end
         if (beat) begin
            se_c <= snap[cnt];
            cnt  <= cnt + 4'd1;
         end
      end
endmodule

// File: tb/tb_systolic_array_4x4.sv
// tb_systolic_array_4x4: scoreboard bench for the 4x4 systolic MAC array
module tb_systolic_array_4x4;
   localparam int ACCW = 40;
`ifdef SYSTOLIC_SKEW_EN
   localparam int SK = 0;
`else
   localparam int SK = 1;
`endif
   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [3:0][15:0] west_in = '0;
   logic [3:0]       west_vld = '0;
   logic [3:0][15:0] north_in = '0;
   logic [3:0]       north_vld = '0;
   logic             acc_clr = 1'b0;
   logic             out_phase = 1'b0;
   logic             se_valid;
   logic [ACCW-1:0]  se_c;
   int               total = 0;
   int               bad = 0;
   int               beats = 0;
   int               ma [4][4];
   int               mb [4][4];
   logic [3:0]       nm;
   logic [ACCW-1:0]  mdl [4][4];
   logic [ACCW-1:0]  sb [$];
   int               sn [16] = '{15, 14, 13, 12, 8, 9, 10, 11, 7, 6, 5, 4, 0, 1, 2, 3};

   systolic_array_4x4 dut (
      .clk(clk), .rst(rst), .west_in(west_in), .west_vld(west_vld),
      .north_in(north_in), .north_vld(north_vld), .acc_clr(acc_clr),
      .out_phase(out_phase), .se_valid(se_valid), .se_c(se_c)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic zero_mdl();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) mdl[r][c] = '0;
   endtask

   task automatic clear();
      acc_clr = 1'b1;
      tick();
      acc_clr = 1'b0;
      zero_mdl();
   endtask

   task automatic set_t1(input int s);
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            ma[r][c] = (r == c) ? s : 0;
            mb[r][c] = 4 * r + c + 1;
         end
      nm = 4'hF;
   endtask

   task automatic tile();
      int kw, kn;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            for (int k = 0; k < 4; k++)
               if (nm[k]) mdl[r][c] = mdl[r][c] + 40'(longint'(ma[r][k]) * longint'(mb[k][c]));
      for (int t = 0; t < 4 + 3 * SK; t++) begin
         for (int i = 0; i < 4; i++) begin
            kw = t - SK * i;
            kn = t - SK * i;
            west_vld[i]  = (kw >= 0 && kw < 4);
            west_in[i]   = (kw >= 0 && kw < 4) ? 16'(ma[i][kw]) : 16'd0;
            north_vld[i] = (kn >= 0 && kn < 4) ? nm[kn] : 1'b0;
            north_in[i]  = (kn >= 0 && kn < 4) ? 16'(mb[kn][i]) : 16'd0;
         end
         tick();
      end
      west_vld  = '0;
      north_vld = '0;
      repeat (10) tick();
   endtask

   task automatic drain(input int pause_after, input int rst_after);
      logic [ACCW-1:0] exp_s [16];
      int n;
      for (int i = 0; i < 16; i++) begin
         exp_s[i] = mdl[sn[i] / 4][sn[i] % 4];
         sb.push_back(exp_s[i]);
      end
      beats = 0;
      out_phase = 1'b1;
      tick();
      chk("latency", 64'(se_valid), 64'd0);
      n = 1;
      while (beats < 16 && n < 60) begin
         if (rst_after != 0 && n == rst_after + 1) begin
            rst = 1'b1;
            out_phase = 1'b0;
            tick();
            chk("rst_drain_vld", 64'(se_valid), 64'd0);
            chk("rst_beats", 64'(beats), 64'(rst_after));
            rst = 1'b0;
            sb.delete();
            zero_mdl();
            tick();
            return;
         end
         if (pause_after != 0 && n == pause_after + 1) begin
            out_phase = 1'b0;
            repeat (3) begin
               tick();
               chk("pause_vld", 64'(se_valid), 64'd0);
            end
            out_phase = 1'b1;
            tick();
            chk("resume_vld", 64'(se_valid), 64'd1);
            chk("resume_c", 64'(se_c), 64'(exp_s[pause_after]));
            n += 4;
         end else begin
            tick();
            n++;
         end
      end
      out_phase = 1'b0;
      repeat (3) tick();
      chk("beats", 64'(beats), 64'd16);
      chk("sb_empty", 64'(sb.size()), 64'd0);
      sb.delete();
   endtask

   always @(negedge clk)
      if (se_valid === 1'b1) begin
         if (sb.size() == 0) chk("extra_beat", 64'(se_valid), 64'd0);
         else chk("se_c", 64'(se_c), 64'(sb.pop_front()));
         beats++;
      end

   initial begin
      zero_mdl();
      repeat (2) tick();
      chk("rst_vld", 64'(se_valid), 64'd0);
      chk("rst_c", 64'(se_c), 64'd0);
      rst = 1'b0;
      tick();
      clear();
      set_t1(1);
      tile();
      drain(0, 0);
      clear();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            ma[r][c] = -32768;
            mb[r][c] = -32768;
         end
      nm = 4'hF;
      tile();
      chk("extreme_mdl", 64'(mdl[0][0]), 64'd4294967296);
      drain(0, 0);
      clear();
      set_t1(1);
      tile();
      clear();
      set_t1(2);
      tile();
      drain(0, 0);
      clear();
      set_t1(1);
      tile();
      drain(5, 0);
      clear();
      set_t1(1);
      tile();
      drain(0, 7);
      drain(0, 0);
      clear();
      set_t1(1);
      nm = 4'b1011;
      tile();
      drain(0, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
